// File: rtl/msdap_pkg.sv
// Shared state encoding and default parameters for the MSDAP sequencer.
package msdap_pkg;

  localparam int unsigned DefNumCh       = 2;
  localparam int unsigned DefRjDepth     = 16;
  localparam int unsigned DefCoeffDepth  = 512;
  localparam int unsigned DefDataDepth   = 256;
  localparam int unsigned DefSleepThresh = 800;

  typedef logic [3:0] state_t;

  localparam state_t StIdle         = 4'd0;
  localparam state_t StInit         = 4'd1;
  localparam state_t StClearing     = 4'd2;
  localparam state_t StWaitRj       = 4'd3;
  localparam state_t StWrRj         = 4'd4;
  localparam state_t StWaitEndRj    = 4'd5;
  localparam state_t StWaitCoeff    = 4'd6;
  localparam state_t StWrCoeff      = 4'd7;
  localparam state_t StWaitEndCoeff = 4'd8;
  localparam state_t StWaitData     = 4'd9;
  localparam state_t StWriteData    = 4'd10;
  localparam state_t StConvClr      = 4'd11;
  localparam state_t StConv         = 4'd12;
  localparam state_t StOutput       = 4'd13;
  localparam state_t StSleeping     = 4'd14;
  localparam state_t StPreClear     = 4'd15;

  // Run-time states in which a flush request aborts work and clears the sample buffer.
  function automatic logic is_run_state(state_t s);
    return (s == StWaitData) || (s == StWriteData) || (s == StConvClr) ||
           (s == StConv) || (s == StOutput) || (s == StSleeping);
  endfunction

endpackage

// File: rtl/msdap_zero_run.sv
// Per-channel run-length counter of consecutive zero samples, saturating at the threshold.
module msdap_zero_run
  import msdap_pkg::*;
#(
  parameter int unsigned SLEEP_THRESH = DefSleepThresh
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic wr_en_i,
  input  logic zero_i,
  output logic sat_o
);

  localparam int unsigned CntW = $clog2(SLEEP_THRESH + 1);
  localparam logic [CntW-1:0] Thresh = CntW'(SLEEP_THRESH);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (wr_en_i) begin
      if (!zero_i) begin
        cnt_d = '0;
      end else if (cnt_q != Thresh) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Reflects the post-update count so the sequencer can decide on the write cycle itself.
  assign sat_o = (cnt_d == Thresh);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/msdap_sequencer.sv
// MSDAP control sequencer: Rj/coefficient load, sample buffering, per-channel convolution
// scheduling, sleep on silence and flush handling. All outputs decode from registered state.
module msdap_sequencer
  import msdap_pkg::*;
#(
  parameter int unsigned NUM_CH       = DefNumCh,
  parameter int unsigned RJ_DEPTH     = DefRjDepth,
  parameter int unsigned COEFF_DEPTH  = DefCoeffDepth,
  parameter int unsigned DATA_DEPTH   = DefDataDepth,
  parameter int unsigned SLEEP_THRESH = DefSleepThresh
) (
  input  logic                                            clk,
  input  logic                                            reset_n,
  input  logic                                            start,
  input  logic                                            frame,
  input  logic                                            flush,
  input  logic [NUM_CH-1:0]                               in_zero,
  input  logic                                            conv_done,
  output logic                                            in_ready,
  output logic                                            rj_wr_en,
  output logic                                            coeff_wr_en,
  output logic                                            data_wr_en,
  output logic                                            data_clear,
  output logic [$clog2(NUM_CH*RJ_DEPTH)-1:0]              rj_addr,
  output logic [$clog2(NUM_CH*COEFF_DEPTH)-1:0]           coeff_addr,
  output logic [$clog2(DATA_DEPTH)-1:0]                   data_addr,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  ch_sel,
  output logic                                            alu_en,
  output logic                                            alu_clear,
  output logic                                            p2s_load,
  output logic                                            s2p_clear,
  output logic                                            p2s_clear,
  output logic                                            sleep,
  output logic                                            overrun
);

  localparam int unsigned RjAw    = $clog2(NUM_CH * RJ_DEPTH);
  localparam int unsigned CoeffAw = $clog2(NUM_CH * COEFF_DEPTH);
  localparam int unsigned DataAw  = $clog2(DATA_DEPTH);
  localparam int unsigned ChW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [RjAw-1:0]    RjLast    = RjAw'(NUM_CH * RJ_DEPTH - 1);
  localparam logic [CoeffAw-1:0] CoeffLast = CoeffAw'(NUM_CH * COEFF_DEPTH - 1);
  localparam logic [DataAw-1:0]  DataLast  = DataAw'(DATA_DEPTH - 1);
  localparam logic [ChW-1:0]     ChLast    = ChW'(NUM_CH - 1);

  state_t              state_q, state_d;
  logic                frame_q;
  logic [RjAw-1:0]     rj_addr_q, rj_addr_d;
  logic [CoeffAw-1:0]  coeff_addr_q, coeff_addr_d;
  logic [DataAw-1:0]   data_addr_q, data_addr_d;
  logic [ChW-1:0]      ch_sel_q, ch_sel_d;
  logic                overrun_q, overrun_d;
  logic                clr_to_data_q, clr_to_data_d;
  logic                frame_rise;
  logic                zr_clear;
  logic [NUM_CH-1:0]   zr_sat;

  assign frame_rise = frame & ~frame_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_zero_run
    msdap_zero_run #(
      .SLEEP_THRESH(SLEEP_THRESH)
    ) u_zero_run (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .clear_i (zr_clear),
      .wr_en_i (state_q == StWriteData),
      .zero_i  (in_zero[c]),
      .sat_o   (zr_sat[c])
    );
  end

  always_comb begin
    state_d       = state_q;
    rj_addr_d     = rj_addr_q;
    coeff_addr_d  = coeff_addr_q;
    data_addr_d   = data_addr_q;
    ch_sel_d      = ch_sel_q;
    overrun_d     = overrun_q;
    clr_to_data_d = clr_to_data_q;
    zr_clear      = 1'b0;

    unique case (state_q)
      StIdle: ;
      StInit: begin
        rj_addr_d     = '0;
        coeff_addr_d  = '0;
        data_addr_d   = '0;
        ch_sel_d      = '0;
        overrun_d     = 1'b0;
        clr_to_data_d = 1'b0;
        zr_clear      = 1'b1;
        state_d       = StClearing;
      end
      StClearing: begin
        data_addr_d = data_addr_q + 1'b1;
        if (data_addr_q == DataLast) begin
          data_addr_d = '0;
          state_d     = clr_to_data_q ? StWaitData : StWaitRj;
        end
      end
      StWaitRj:    if (frame_rise) state_d = StWrRj;
      StWrRj:      state_d = StWaitEndRj;
      StWaitEndRj: begin
        if (!frame) begin
          rj_addr_d = (rj_addr_q == RjLast) ? '0 : rj_addr_q + 1'b1;
          state_d   = (rj_addr_q == RjLast) ? StWaitCoeff : StWaitRj;
        end
      end
      StWaitCoeff: if (frame_rise) state_d = StWrCoeff;
      StWrCoeff:   state_d = StWaitEndCoeff;
      StWaitEndCoeff: begin
        if (!frame) begin
          coeff_addr_d = (coeff_addr_q == CoeffLast) ? '0 : coeff_addr_q + 1'b1;
          state_d      = (coeff_addr_q == CoeffLast) ? StWaitData : StWaitCoeff;
        end
      end
      StWaitData:  if (frame_rise) state_d = StWriteData;
      StWriteData: begin
        data_addr_d = data_addr_q + 1'b1;
        ch_sel_d    = '0;
        state_d     = (&zr_sat) ? StSleeping : StConvClr;
      end
      StConvClr: begin
        if (frame_rise) overrun_d = 1'b1;
        state_d = StConv;
      end
      StConv: begin
        if (frame_rise) overrun_d = 1'b1;
        if (conv_done) begin
          if (ch_sel_q == ChLast) begin
            state_d = StOutput;
          end else begin
            ch_sel_d = ch_sel_q + 1'b1;
            state_d  = StConvClr;
          end
        end
      end
      StOutput: begin
        ch_sel_d = '0;
        state_d  = StWaitData;
      end
      StSleeping: begin
        // Silent frames are dropped; a frame with any live channel wakes and gets written.
        if (frame_rise && !(&in_zero)) begin
          zr_clear = 1'b1;
          state_d  = StWriteData;
        end
      end
      StPreClear: begin
        data_addr_d   = '0;
        ch_sel_d      = '0;
        zr_clear      = 1'b1;
        clr_to_data_d = 1'b1;
        state_d       = StClearing;
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d = StInit;
    end else if (flush && is_run_state(state_q)) begin
      state_d = StPreClear;
    end
  end

  always_comb begin
    in_ready    = !((state_q == StIdle) || (state_q == StInit) ||
                    (state_q == StClearing) || (state_q == StPreClear));
    rj_wr_en    = (state_q == StWrRj);
    coeff_wr_en = (state_q == StWrCoeff);
    data_clear  = (state_q == StClearing);
    data_wr_en  = (state_q == StClearing) || (state_q == StWriteData);
    alu_clear   = (state_q == StConvClr);
    alu_en      = (state_q == StConv);
    p2s_load    = (state_q == StOutput);
    s2p_clear   = (state_q == StInit) || (state_q == StPreClear);
    p2s_clear   = (state_q == StInit) || (state_q == StPreClear);
    sleep       = (state_q == StSleeping);
    overrun     = overrun_q;
    rj_addr     = rj_addr_q;
    coeff_addr  = coeff_addr_q;
    data_addr   = data_addr_q;
    ch_sel      = ch_sel_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      frame_q       <= 1'b0;
      rj_addr_q     <= '0;
      coeff_addr_q  <= '0;
      data_addr_q   <= '0;
      ch_sel_q      <= '0;
      overrun_q     <= 1'b0;
      clr_to_data_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame;
      rj_addr_q     <= rj_addr_d;
      coeff_addr_q  <= coeff_addr_d;
      data_addr_q   <= data_addr_d;
      ch_sel_q      <= ch_sel_d;
      overrun_q     <= overrun_d;
      clr_to_data_q <= clr_to_data_d;
    end
  end

endmodule

// File: tb/tb_msdap_sequencer.sv
// Scoreboard bench for msdap_sequencer: expected strobe events are queued as frames are
// driven and matched against the DUT's write, alu_clear and p2s_load strobes.
module tb_msdap_sequencer;

  localparam int NumCh      = 2;
  localparam int RjWords    = 32;
  localparam int CoeffWords = 1024;
  localparam int Depth      = 256;
  localparam int Thresh     = 800;

  localparam int KRj     = 1;
  localparam int KCoeff  = 2;
  localparam int KData   = 3;
  localparam int KAluClr = 4;
  localparam int KP2s    = 5;

  logic       clk = 1'b0;
  logic       reset_n, start, frame, flush, conv_done;
  logic [1:0] in_zero;
  logic       in_ready, rj_wr_en, coeff_wr_en, data_wr_en, data_clear;
  logic [4:0] rj_addr;
  logic [9:0] coeff_addr;
  logic [7:0] data_addr;
  logic       ch_sel;
  logic       alu_en, alu_clear, p2s_load, s2p_clear, p2s_clear, sleep, overrun;
  logic [35:0] outs;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  int          lat = 10;
  int          resp_cnt = 0;
  int          wp = 0;
  int          zr[NumCh];
  bit          sleeping = 0;
  int          rj_cnt = 0;
  int          coeff_cnt = 0;

  msdap_sequencer #(
    .NUM_CH      (NumCh),
    .RJ_DEPTH    (16),
    .COEFF_DEPTH (512),
    .DATA_DEPTH  (Depth),
    .SLEEP_THRESH(Thresh)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .frame      (frame),
    .flush      (flush),
    .in_zero    (in_zero),
    .conv_done  (conv_done),
    .in_ready   (in_ready),
    .rj_wr_en   (rj_wr_en),
    .coeff_wr_en(coeff_wr_en),
    .data_wr_en (data_wr_en),
    .data_clear (data_clear),
    .rj_addr    (rj_addr),
    .coeff_addr (coeff_addr),
    .data_addr  (data_addr),
    .ch_sel     (ch_sel),
    .alu_en     (alu_en),
    .alu_clear  (alu_clear),
    .p2s_load   (p2s_load),
    .s2p_clear  (s2p_clear),
    .p2s_clear  (p2s_clear),
    .sleep      (sleep),
    .overrun    (overrun)
  );

  assign outs = {in_ready, rj_wr_en, coeff_wr_en, data_wr_en, data_clear, rj_addr, coeff_addr,
                 data_addr, ch_sel, alu_en, alu_clear, p2s_load, s2p_clear, p2s_clear, sleep,
                 overrun};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ev(input int k, input int a);
    return {8'(k), 24'(a)};
  endfunction

  task automatic sb_pop(input string tag, input logic [31:0] got);
    logic [31:0] exp;
    check_eq("sb_unexpected_event", 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check_eq(tag, 64'(got), 64'(exp));
    end
  endtask

  // Event monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (rj_wr_en) begin
        rj_cnt++;
        sb_pop("rj_write", ev(KRj, int'(rj_addr)));
      end
      if (coeff_wr_en) begin
        coeff_cnt++;
        sb_pop("coeff_write", ev(KCoeff, int'(coeff_addr)));
      end
      if (data_wr_en && !data_clear) sb_pop("data_write", ev(KData, int'(data_addr)));
      if (alu_clear) sb_pop("alu_clear", ev(KAluClr, int'(ch_sel)));
      if (p2s_load) sb_pop("p2s_load", ev(KP2s, 0));
    end
  end

  // ALU model: raises conv_done after lat cycles of alu_en.
  initial begin
    conv_done = 1'b0;
    forever begin
      @(negedge clk);
      if (alu_en === 1'b1 && !conv_done) begin
        resp_cnt++;
        if (resp_cnt >= lat) conv_done = 1'b1;
      end else begin
        conv_done = 1'b0;
        resp_cnt  = 0;
      end
    end
  end

  task automatic drive_frame(input logic [1:0] mask);
    @(negedge clk);
    in_zero = mask;
    frame   = 1'b1;
    repeat (2) @(negedge clk);
    frame = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic data_frame(input logic [1:0] mask);
    bit all_sat;
    if (!(sleeping && mask == 2'b11)) begin
      if (sleeping) begin
        for (int c = 0; c < NumCh; c++) zr[c] = 0;
        sleeping = 0;
      end
      sb.push_back(ev(KData, wp));
      wp = (wp + 1) % Depth;
      all_sat = 1;
      for (int c = 0; c < NumCh; c++) begin
        zr[c] = mask[c] ? ((zr[c] < Thresh) ? zr[c] + 1 : Thresh) : 0;
        if (zr[c] != Thresh) all_sat = 0;
      end
      sleeping = all_sat;
      if (!sleeping) begin
        for (int c = 0; c < NumCh; c++) sb.push_back(ev(KAluClr, c));
        sb.push_back(ev(KP2s, 0));
      end
    end
    drive_frame(mask);
    repeat (NumCh * (lat + 2) + 4) @(negedge clk);
  endtask

  task automatic clear_check();
    for (int i = 0; i < Depth; i++) begin
      check_eq("clear_strobes", 64'({data_clear, data_wr_en}), 64'd3);
      check_eq("clear_addr", 64'(data_addr), 64'(i));
      @(negedge clk);
    end
    check_eq("clear_done", 64'({data_clear, in_ready}), 64'd1);
  endtask

  task automatic push_conv_start();
    sb.push_back(ev(KData, wp));
    wp = (wp + 1) % Depth;
    for (int c = 0; c < NumCh; c++) zr[c] = 0;
    sb.push_back(ev(KAluClr, 0));
  endtask

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    frame   = 1'b0;
    flush   = 1'b0;
    in_zero = 2'b00;
    for (int c = 0; c < NumCh; c++) zr[c] = 0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", 64'(outs), 64'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("idle_hold", 64'(outs), 64'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("init_strobes", 64'({s2p_clear, p2s_clear, in_ready}), 64'd6);
    @(negedge clk);
    clear_check();

    for (int i = 0; i < RjWords; i++) begin
      sb.push_back(ev(KRj, i));
      drive_frame(2'b00);
    end
    for (int i = 0; i < CoeffWords; i++) begin
      sb.push_back(ev(KCoeff, i));
      drive_frame(2'b00);
    end
    check_eq("load_queue_empty", 64'(sb.size()), 64'd0);
    check_eq("wait_data_ready", 64'({in_ready, data_wr_en}), 64'd2);

    lat = 10;
    for (int i = 0; i < Depth + 1; i++) data_frame(2'b00);
    check_eq("data_queue_empty", 64'(sb.size()), 64'd0);

    lat = 3;
    for (int i = 0; i < Thresh - 1; i++) data_frame(2'b11);
    check_eq("awake_before_thresh", 64'(sleep), 64'd0);
    data_frame(2'b11);
    check_eq("sleep_at_thresh", 64'(sleep), 64'd1);
    data_frame(2'b11);
    check_eq("sleep_hold", 64'(sleep), 64'd1);
    data_frame(2'b01);
    check_eq("wake", 64'(sleep), 64'd0);
    check_eq("sleep_queue_empty", 64'(sb.size()), 64'd0);

    lat = 10;
    check_eq("overrun_clear", 64'(overrun), 64'd0);
    push_conv_start();
    sb.push_back(ev(KAluClr, 1));
    sb.push_back(ev(KP2s, 0));
    drive_frame(2'b00);
    check_eq("in_conv_ch0", 64'({alu_en, ch_sel}), 64'd2);
    frame = 1'b1;
    repeat (2) @(negedge clk);
    frame = 1'b0;
    repeat (2 * (lat + 2) + 4) @(negedge clk);
    check_eq("overrun_set", 64'(overrun), 64'd1);
    check_eq("overrun_queue_empty", 64'(sb.size()), 64'd0);
    data_frame(2'b00);
    check_eq("overrun_sticky", 64'(overrun), 64'd1);

    lat = 1000;
    push_conv_start();
    drive_frame(2'b00);
    check_eq("flush_in_conv", 64'({alu_en, ch_sel}), 64'd2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("pre_clear", 64'({s2p_clear, p2s_clear, in_ready, alu_en}), 64'd12);
    @(negedge clk);
    clear_check();
    wp = 0;
    check_eq("flush_queue_empty", 64'(sb.size()), 64'd0);
    lat = 3;
    data_frame(2'b00);
    check_eq("overrun_kept_flush", 64'(overrun), 64'd1);
    check_eq("rj_write_count", 64'(rj_cnt), 64'(RjWords));
    check_eq("coeff_write_count", 64'(coeff_cnt), 64'(CoeffWords));

    lat = 1000;
    push_conv_start();
    drive_frame(2'b00);
    check_eq("reset_in_conv", 64'({alu_en, ch_sel}), 64'd2);
    #2 reset_n = 1'b0;
    #1 check_eq("async_reset_outputs", 64'(outs), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("idle_after_reset", 64'(outs), 64'd0);
    check_eq("final_queue_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
